// File: rtl/ldst_mem_ctrl.sv
// ldst_mem_ctrl: data-memory controller between the LDST stage and a
// single-port, word-wide SRAM.
//   core_*  : byte/half/word loads and stores from the core. Sub-word stores
//             become a read-modify-write pair; ldst_stall holds the core.
//   ldr_*   : word-only loader/debug port that shares the SRAM.
//   mem_*   : SRAM strobes (active-low csb/web). Read data is expected one
//             cycle after the read strobe.
// In IDLE, commands are driven combinationally in the acceptance cycle.
// CLD, RMW and LLD are the registered second cycles of 2-cycle operations.
module ldst_mem_ctrl #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 15
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst_n,
  input  logic                 core_req_i,
  input  logic                 core_we_i,
  input  logic [2:0]           core_func3_i,
  input  logic [31:0]          core_addr_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  output logic                 ldst_stall,
  output logic [DataWidth-1:0] core_rdata_o,
  output logic                 core_rvalid_o,
  output logic                 core_err_o,
  input  logic                 ldr_req_i,
  input  logic                 ldr_we_i,
  input  logic [AddrWidth-1:0] ldr_addr_i,
  input  logic [DataWidth-1:0] ldr_wdata_i,
  output logic                 ldr_gnt_o,
  output logic                 ldr_rvalid_o,
  output logic [DataWidth-1:0] ldr_rdata_o,
  output logic                 mem_csb_o,
  output logic                 mem_web_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic [DataWidth-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, CLD, RMW, LLD} state_t;

  state_t               state, state_nxt;
  logic                 last_core;  // 1: last grant went to the core
  logic [AddrWidth-1:0] cap_addr;
  logic [1:0]           cap_lane;
  logic [2:0]           cap_f3;
  logic [15:0]          cap_wdata;

  logic                 core_err, core_gnt, ldr_gnt, idle_ok, misalign, bad_f3;
  logic [AddrWidth-1:0] core_word;
  logic [7:0]           lane_b;
  logic [15:0]          lane_h;
  logic [DataWidth-1:0] load_ext, merged;
  logic                 unused_addr;

  assign unused_addr = ^core_addr_i[31:AddrWidth+2];
  assign core_word   = core_addr_i[AddrWidth+1:2];

  assign bad_f3   = (core_func3_i == 3'b011) || (core_func3_i[2:1] == 2'b11);
  assign misalign = ((core_func3_i[1:0] == 2'b01) && core_addr_i[0]) ||
                    ((core_func3_i[1:0] == 2'b10) && (core_addr_i[1:0] != 2'b00));
  assign core_err = bad_f3 | misalign;

  // Acceptance is gated by reset so the IDLE combinational command path
  // cannot strobe the SRAM while reset is asserted.
  assign idle_ok  = (state == IDLE) && brq_rst_n;
  assign core_gnt = idle_ok && core_req_i && (!ldr_req_i || !last_core);
  assign ldr_gnt  = idle_ok && ldr_req_i && !core_gnt;

  // Lane extraction (CLD) and lane merge (RMW) use the captured request.
  always_comb begin
    lane_b   = mem_rdata_i[{cap_lane, 3'b000} +: 8];
    lane_h   = mem_rdata_i[{cap_lane[1], 4'b0000} +: 16];
    load_ext = mem_rdata_i;
    case (cap_f3)
      3'b000:  load_ext = {{(DataWidth-8){lane_b[7]}}, lane_b};
      3'b100:  load_ext = {{(DataWidth-8){1'b0}}, lane_b};
      3'b001:  load_ext = {{(DataWidth-16){lane_h[15]}}, lane_h};
      3'b101:  load_ext = {{(DataWidth-16){1'b0}}, lane_h};
      default: load_ext = mem_rdata_i;
    endcase
    merged = mem_rdata_i;
    if (cap_f3[0]) merged[{cap_lane[1], 4'b0000} +: 16] = cap_wdata;
    else           merged[{cap_lane, 3'b000} +: 8]      = cap_wdata[7:0];
  end

  always_comb begin
    state_nxt     = state;
    ldst_stall    = 1'b0;
    core_rdata_o  = '0;
    core_rvalid_o = 1'b0;
    core_err_o    = 1'b0;
    ldr_gnt_o     = 1'b0;
    ldr_rvalid_o  = 1'b0;
    ldr_rdata_o   = '0;
    mem_csb_o     = 1'b1;
    mem_web_o     = 1'b1;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    case (state)
      IDLE: begin
        if (core_gnt) begin
          if (core_err) begin
            core_err_o = 1'b1;
          end else begin
            mem_csb_o  = 1'b0;
            mem_addr_o = core_word;
            if (core_we_i && core_func3_i[1:0] == 2'b10) begin
              mem_web_o   = 1'b0;
              mem_wdata_o = core_wdata_i;
            end else begin
              // loads and sub-word stores both start with a read
              ldst_stall = 1'b1;
              state_nxt  = core_we_i ? RMW : CLD;
            end
          end
        end else if (ldr_gnt) begin
          ldr_gnt_o  = 1'b1;
          mem_csb_o  = 1'b0;
          mem_addr_o = ldr_addr_i;
          if (ldr_we_i) begin
            mem_web_o   = 1'b0;
            mem_wdata_o = ldr_wdata_i;
          end else begin
            state_nxt = LLD;
          end
        end
        if (idle_ok && core_req_i && !core_gnt) ldst_stall = 1'b1;
      end
      CLD: begin
        core_rvalid_o = 1'b1;
        core_rdata_o  = load_ext;
        state_nxt     = IDLE;
      end
      RMW: begin
        mem_csb_o   = 1'b0;
        mem_web_o   = 1'b0;
        mem_addr_o  = cap_addr;
        mem_wdata_o = merged;
        state_nxt   = IDLE;
      end
      LLD: begin
        ldr_rvalid_o = 1'b1;
        ldr_rdata_o  = mem_rdata_i;
        ldst_stall   = core_req_i;  // core waits behind the loader read
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge brq_clk or negedge brq_rst_n) begin
    if (!brq_rst_n) begin
      state     <= IDLE;
      last_core <= 1'b0;
      cap_addr  <= '0;
      cap_lane  <= '0;
      cap_f3    <= '0;
      cap_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (core_gnt)     last_core <= 1'b1;
      else if (ldr_gnt) last_core <= 1'b0;
      if (core_gnt && !core_err) begin
        cap_addr  <= core_word;
        cap_lane  <= core_addr_i[1:0];
        cap_f3    <= core_func3_i;
        cap_wdata <= core_wdata_i[15:0];
      end
    end
  end

endmodule

// File: tb/tb_ldst_mem_ctrl.sv
// Directed bench for ldst_mem_ctrl with a small behavioural SRAM (16 words,
// registered read data) and a backdoor preload port.
module tb_ldst_mem_ctrl;
  logic        brq_clk, brq_rst_n;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_func3_i;
  logic [31:0] core_addr_i, core_wdata_i;
  logic        ldst_stall;
  logic [31:0] core_rdata_o;
  logic        core_rvalid_o, core_err_o;
  logic        ldr_req_i, ldr_we_i;
  logic [14:0] ldr_addr_i;
  logic [31:0] ldr_wdata_i;
  logic        ldr_gnt_o, ldr_rvalid_o;
  logic [31:0] ldr_rdata_o;
  logic        mem_csb_o, mem_web_o;
  logic [14:0] mem_addr_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] sram [0:15];
  logic        bd_we;
  logic [3:0]  bd_addr;
  logic [31:0] bd_data;

  ldst_mem_ctrl dut (
    .brq_clk(brq_clk), .brq_rst_n(brq_rst_n),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_func3_i(core_func3_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .ldst_stall(ldst_stall), .core_rdata_o(core_rdata_o),
    .core_rvalid_o(core_rvalid_o), .core_err_o(core_err_o),
    .ldr_req_i(ldr_req_i), .ldr_we_i(ldr_we_i), .ldr_addr_i(ldr_addr_i),
    .ldr_wdata_i(ldr_wdata_i), .ldr_gnt_o(ldr_gnt_o), .ldr_rvalid_o(ldr_rvalid_o),
    .ldr_rdata_o(ldr_rdata_o), .mem_csb_o(mem_csb_o), .mem_web_o(mem_web_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  initial brq_clk = 1'b0;
  always #5 brq_clk = ~brq_clk;

  always @(posedge brq_clk) begin
    if (bd_we) sram[bd_addr] <= bd_data;
    else if (!mem_csb_o) begin
      if (!mem_web_o) sram[mem_addr_o[3:0]] <= mem_wdata_o;
      else            mem_rdata_i <= sram[mem_addr_o[3:0]];
    end
  end

  task automatic step();
    @(posedge brq_clk); #1;
  endtask

  task automatic poke(input logic [3:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    step();
    bd_we = 1'b0;
  endtask

  task automatic core_drive(input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d);
    core_req_i = 1'b1; core_we_i = we; core_func3_i = f3;
    core_addr_i = a; core_wdata_i = d;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (mem_csb_o !== 1'b1) begin errors++; $display("FAIL rst_csb got %b exp 1", mem_csb_o); end
    checks++; if (mem_web_o !== 1'b1) begin errors++; $display("FAIL rst_web got %b exp 1", mem_web_o); end
    checks++; if (mem_addr_o !== 15'd0) begin errors++; $display("FAIL rst_addr got %h exp 0", mem_addr_o); end
    checks++; if (mem_wdata_o !== 32'd0) begin errors++; $display("FAIL rst_wdata got %h exp 0", mem_wdata_o); end
    checks++; if (ldst_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", ldst_stall); end
    checks++; if ({core_rvalid_o, core_err_o, ldr_gnt_o, ldr_rvalid_o} !== 4'b0)
      begin errors++; $display("FAIL rst_flags got %b exp 0000", {core_rvalid_o, core_err_o, ldr_gnt_o, ldr_rvalid_o}); end
    checks++; if ({core_rdata_o, ldr_rdata_o} !== 64'd0)
      begin errors++; $display("FAIL rst_rdata got %h exp 0", {core_rdata_o, ldr_rdata_o}); end
    core_req_i = 1'b0; ldr_req_i = 1'b0;
    brq_rst_n = 1'b1;
    step();
  endtask

  task automatic test_load();
    logic [2:0]  f3s [4];
    logic [31:0] ads [4];
    logic [31:0] exps [4];
    f3s  = '{3'b000, 3'b100, 3'b001, 3'b101};
    ads  = '{32'h6, 32'h6, 32'h4, 32'h6};
    exps = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_7F01, 32'h0000_80FF};
    poke(4'd1, 32'h80FF_7F01);
    for (int i = 0; i < 4; i++) begin
      core_drive(1'b0, f3s[i], ads[i], 32'h0);
      #4;
      checks++; if ({mem_csb_o, mem_web_o, ldst_stall} !== 3'b011)
        begin errors++; $display("FAIL ld%0d_issue csb/web/stall got %b exp 011", i, {mem_csb_o, mem_web_o, ldst_stall}); end
      checks++; if (mem_addr_o !== 15'd1) begin errors++; $display("FAIL ld%0d_addr got %h exp 1", i, mem_addr_o); end
      step(); #4;
      checks++; if ({core_rvalid_o, ldst_stall, mem_csb_o} !== 3'b101)
        begin errors++; $display("FAIL ld%0d_done rvalid/stall/csb got %b exp 101", i, {core_rvalid_o, ldst_stall, mem_csb_o}); end
      checks++; if (core_rdata_o !== exps[i]) begin errors++; $display("FAIL ld%0d_data got %h exp %h", i, core_rdata_o, exps[i]); end
      step();
    end
    core_req_i = 1'b0;
    step();
  endtask

  task automatic test_rmw();
    poke(4'd2, 32'h1122_3344);
    core_drive(1'b1, 3'b000, 32'h9, 32'hDEAD_BEA5);
    #4;
    checks++; if ({mem_csb_o, mem_web_o, ldst_stall} !== 3'b011)
      begin errors++; $display("FAIL sb_read csb/web/stall got %b exp 011", {mem_csb_o, mem_web_o, ldst_stall}); end
    step(); #4;
    checks++; if ({mem_csb_o, mem_web_o, ldst_stall} !== 3'b000)
      begin errors++; $display("FAIL sb_write csb/web/stall got %b exp 000", {mem_csb_o, mem_web_o, ldst_stall}); end
    checks++; if (mem_wdata_o !== 32'h1122_A544) begin errors++; $display("FAIL sb_wdata got %h exp 1122a544", mem_wdata_o); end
    checks++; if (mem_addr_o !== 15'd2) begin errors++; $display("FAIL sb_addr got %h exp 2", mem_addr_o); end
    step();
    core_drive(1'b0, 3'b010, 32'h8, 32'h0);
    step(); #4;
    checks++; if (core_rdata_o !== 32'h1122_A544 || core_rvalid_o !== 1'b1)
      begin errors++; $display("FAIL lw_after_sb got %h/%b exp 1122a544/1", core_rdata_o, core_rvalid_o); end
    step();
    core_drive(1'b1, 3'b001, 32'hA, 32'h1234_BEEF);
    step(); #4;
    checks++; if (mem_wdata_o !== 32'hBEEF_A544 || mem_web_o !== 1'b0)
      begin errors++; $display("FAIL sh_wdata got %h/%b exp beefa544/0", mem_wdata_o, mem_web_o); end
    step();
    core_drive(1'b1, 3'b010, 32'hC, 32'h1234_5678);
    #4;
    checks++; if ({mem_csb_o, mem_web_o, ldst_stall} !== 3'b000 || mem_wdata_o !== 32'h1234_5678 || mem_addr_o !== 15'd3)
      begin errors++; $display("FAIL sw got %b %h %h exp 000 12345678 3", {mem_csb_o, mem_web_o, ldst_stall}, mem_wdata_o, mem_addr_o); end
    step();
    core_req_i = 1'b0;
    #4;
    checks++; if (mem_csb_o !== 1'b1 || core_rvalid_o !== 1'b0)
      begin errors++; $display("FAIL sw_after csb/rvalid got %b%b exp 10", mem_csb_o, core_rvalid_o); end
    checks++; if (sram[3] !== 32'h1234_5678 || sram[2] !== 32'hBEEF_A544)
      begin errors++; $display("FAIL mem_contents got %h %h exp 12345678 beefa544", sram[3], sram[2]); end
    step();
  endtask

  task automatic test_error();
    logic [2:0]  f3s [3];
    logic        wes [3];
    logic [31:0] ads [3];
    f3s = '{3'b001, 3'b010, 3'b011};
    wes = '{1'b1, 1'b0, 1'b0};
    ads = '{32'h3, 32'h2, 32'h0};
    for (int i = 0; i < 3; i++) begin
      core_drive(wes[i], f3s[i], ads[i], 32'hFFFF_FFFF);
      #4;
      checks++; if ({core_err_o, mem_csb_o, ldst_stall, core_rvalid_o} !== 4'b1100)
        begin errors++; $display("FAIL err%0d err/csb/stall/rvalid got %b exp 1100", i, {core_err_o, mem_csb_o, ldst_stall, core_rvalid_o}); end
      step();
    end
    core_req_i = 1'b0;
    #4;
    checks++; if ({core_err_o, core_rvalid_o, mem_csb_o} !== 3'b001)
      begin errors++; $display("FAIL err_after err/rvalid/csb got %b exp 001", {core_err_o, core_rvalid_o, mem_csb_o}); end
    step();
  endtask

  task automatic test_loader();
    ldr_req_i = 1'b1; ldr_we_i = 1'b0; ldr_addr_i = 15'd1; ldr_wdata_i = 32'h0;
    #4;
    checks++; if ({ldr_gnt_o, mem_csb_o, mem_web_o} !== 3'b101 || mem_addr_o !== 15'd1)
      begin errors++; $display("FAIL ldr_rd_issue got %b %h exp 101 1", {ldr_gnt_o, mem_csb_o, mem_web_o}, mem_addr_o); end
    step();
    ldr_req_i = 1'b0;
    core_drive(1'b0, 3'b010, 32'h4, 32'h0);
    #4;
    checks++; if (ldr_rvalid_o !== 1'b1 || ldr_rdata_o !== 32'h80FF_7F01)
      begin errors++; $display("FAIL ldr_rd_data got %b %h exp 1 80ff7f01", ldr_rvalid_o, ldr_rdata_o); end
    checks++; if (ldst_stall !== 1'b1 || mem_csb_o !== 1'b1)
      begin errors++; $display("FAIL lld_core_wait stall/csb got %b%b exp 11", ldst_stall, mem_csb_o); end
    step(); #4;
    checks++; if ({mem_csb_o, ldst_stall} !== 2'b01)
      begin errors++; $display("FAIL after_lld_issue csb/stall got %b exp 01", {mem_csb_o, ldst_stall}); end
    step(); #4;
    checks++; if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'h80FF_7F01)
      begin errors++; $display("FAIL after_lld_data got %b %h exp 1 80ff7f01", core_rvalid_o, core_rdata_o); end
    step();
    core_req_i = 1'b0;
    step();
  endtask

  task automatic test_contention();
    brq_rst_n = 1'b0; #2; brq_rst_n = 1'b1;
    step();
    core_drive(1'b0, 3'b010, 32'h8, 32'h0);
    ldr_req_i = 1'b1; ldr_we_i = 1'b1; ldr_addr_i = 15'd5; ldr_wdata_i = 32'hCAFE_F00D;
    #4;
    checks++; if ({ldr_gnt_o, ldst_stall, mem_csb_o, mem_web_o} !== 4'b0101 || mem_addr_o !== 15'd2)
      begin errors++; $display("FAIL cont_a got %b %h exp 0101 2", {ldr_gnt_o, ldst_stall, mem_csb_o, mem_web_o}, mem_addr_o); end
    step(); #4;
    checks++; if ({core_rvalid_o, ldr_gnt_o} !== 2'b10 || core_rdata_o !== 32'hBEEF_A544)
      begin errors++; $display("FAIL cont_b got %b %h exp 10 beefa544", {core_rvalid_o, ldr_gnt_o}, core_rdata_o); end
    step(); #4;
    checks++; if ({ldr_gnt_o, ldst_stall, mem_csb_o, mem_web_o} !== 4'b1100 || mem_addr_o !== 15'd5 || mem_wdata_o !== 32'hCAFE_F00D)
      begin errors++; $display("FAIL cont_c got %b %h %h exp 1100 5 cafef00d", {ldr_gnt_o, ldst_stall, mem_csb_o, mem_web_o}, mem_addr_o, mem_wdata_o); end
    step(); #4;
    checks++; if ({ldr_gnt_o, ldst_stall, mem_web_o} !== 3'b011)
      begin errors++; $display("FAIL cont_d gnt/stall/web got %b exp 011", {ldr_gnt_o, ldst_stall, mem_web_o}); end
    step(); #4;
    checks++; if (core_rvalid_o !== 1'b1) begin errors++; $display("FAIL cont_e rvalid got %b exp 1", core_rvalid_o); end
    step(); #4;
    checks++; if (ldr_gnt_o !== 1'b1) begin errors++; $display("FAIL cont_f gnt got %b exp 1", ldr_gnt_o); end
    step();
    core_req_i = 1'b0; ldr_req_i = 1'b0;
    #4;
    checks++; if (sram[5] !== 32'hCAFE_F00D) begin errors++; $display("FAIL cont_mem got %h exp cafef00d", sram[5]); end
    step();
  endtask

  task automatic test_reset_rmw();
    poke(4'd2, 32'h1122_3344);
    core_drive(1'b1, 3'b000, 32'h9, 32'h0000_00A5);
    #4;
    checks++; if (ldst_stall !== 1'b1) begin errors++; $display("FAIL rrmw_stall got %b exp 1", ldst_stall); end
    #2; brq_rst_n = 1'b0; #1;
    checks++; if ({mem_csb_o, mem_web_o, ldst_stall} !== 3'b110)
      begin errors++; $display("FAIL rrmw_async csb/web/stall got %b exp 110", {mem_csb_o, mem_web_o, ldst_stall}); end
    core_req_i = 1'b0;
    step();
    brq_rst_n = 1'b1;
    #4;
    checks++; if ({mem_csb_o, mem_web_o} !== 2'b11) begin errors++; $display("FAIL rrmw_nowrite got %b exp 11", {mem_csb_o, mem_web_o}); end
    step(); #4;
    checks++; if (sram[2] !== 32'h1122_3344) begin errors++; $display("FAIL rrmw_mem got %h exp 11223344", sram[2]); end
    step();
    core_drive(1'b0, 3'b010, 32'h4, 32'h0);
    #6; brq_rst_n = 1'b0; #1;
    core_req_i = 1'b0;
    checks++; if ({core_rvalid_o, ldst_stall} !== 2'b00) begin errors++; $display("FAIL rld_async got %b exp 00", {core_rvalid_o, ldst_stall}); end
    step();
    brq_rst_n = 1'b1;
    #4;
    checks++; if (core_rvalid_o !== 1'b0) begin errors++; $display("FAIL rld_norvalid got %b exp 0", core_rvalid_o); end
    step(); #4;
    checks++; if (core_rvalid_o !== 1'b0) begin errors++; $display("FAIL rld_norvalid2 got %b exp 0", core_rvalid_o); end
    step();
  endtask

  initial begin
    brq_rst_n = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    core_req_i = 1'b1; core_we_i = 1'b0; core_func3_i = 3'b010;
    core_addr_i = 32'h4; core_wdata_i = 32'h0;
    ldr_req_i = 1'b1; ldr_we_i = 1'b1; ldr_addr_i = 15'd3; ldr_wdata_i = 32'h5555_5555;
    test_reset();
    test_load();
    test_rmw();
    test_error();
    test_loader();
    test_contention();
    test_reset_rmw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
